// File: rtl/alarm_pkg.sv
// Shared constants for the alarm circuit: decode truth table and default counter width.
package alarm_pkg;

  // Bit n set means code n raises the alarm.
  localparam logic [31:0] ALARM_TT  = 32'hB32D_224C;
  localparam int          CNT_W_DEF = 8;

endpackage

// File: rtl/alarm_decode.sv
// Combinational alarm decode: 5-bit sensor code to alarm bit via table lookup.
module alarm_decode
  import alarm_pkg::*;
(
  input  logic [4:0] code,
  output logic       y
);

  assign y = ALARM_TT[code];

endmodule

// File: rtl/alarm_circuit.sv
// Alarm circuit: decoded alarm, its registered copy, sticky flag and saturating rising-edge counter.
module alarm_circuit
  import alarm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x4,
  input  logic             x3,
  input  logic             x2,
  input  logic             x1,
  input  logic             x0,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             alarm_sticky,
  output logic [CNT_W-1:0] alarm_cnt
);

  logic [4:0]       w_x;
  logic             w_rise;
  logic             r_y_q;
  logic             r_y_q_prev;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_x = {x4, x3, x2, x1, x0};

  alarm_decode u_decode (
    .code (w_x),
    .y    (y)
  );

  assign w_rise = r_y_q & ~r_y_q_prev;

  // Stage boundary: decode -> registered alarm, edge detect, sticky and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q      <= 1'b0;
      r_y_q_prev <= 1'b0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_y_q      <= y;
      r_y_q_prev <= r_y_q;
      // Clear beats a coincident rising edge.
      if (clr) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else begin
        if (r_y_q)  r_sticky <= 1'b1;
        if (w_rise) r_cnt    <= sat_inc(r_cnt);
      end
    end
  end

  assign y_q          = r_y_q;
  assign alarm_sticky = r_sticky;
  assign alarm_cnt    = r_cnt;

endmodule

// File: tb/tb_alarm_circuit.sv
// Directed, table-driven bench for alarm_circuit (default width plus a 2-bit counter instance).
module tb_alarm_circuit;

  logic       clk;
  logic       rst;
  logic [4:0] x;
  logic       clr;
  logic       y8, yq8, st8;
  logic [7:0] cnt8;
  logic       y2, yq2, st2;
  logic [1:0] cnt2;

  int tests;
  int fails;

  alarm_circuit #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .x4(x[4]), .x3(x[3]), .x2(x[2]), .x1(x[1]), .x0(x[0]),
    .clr(clr), .y(y8), .y_q(yq8), .alarm_sticky(st8), .alarm_cnt(cnt8)
  );

  alarm_circuit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x4(x[4]), .x3(x[3]), .x2(x[2]), .x1(x[1]), .x0(x[0]),
    .clr(clr), .y(y2), .y_q(yq2), .alarm_sticky(st2), .alarm_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] x;
    logic       clr;
    logic       rst;
    logic       exp_y;
    logic       exp_yq;
    logic       exp_st;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[28];
  int   alarm_codes[14] = '{2, 3, 6, 9, 13, 16, 18, 19, 21, 24, 25, 28, 29, 31};

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] xi, input logic c, input logic r,
                              input logic ey, input logic eq, input logic es, input logic [7:0] ec);
    vec_t v;
    v.x = xi; v.clr = c; v.rst = r; v.exp_y = ey; v.exp_yq = eq; v.exp_st = es; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    tests = 0;
    fails = 0;

    // Per-cycle vectors: inputs applied, y checked before the edge, registers checked after it.
    vecs[0]  = mk(5'd0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(5'd9,  0, 0, 1, 1, 0, 0);
    vecs[2]  = mk(5'd0,  0, 0, 0, 0, 1, 1);
    vecs[3]  = mk(5'd9,  0, 0, 1, 1, 1, 1);
    vecs[4]  = mk(5'd0,  0, 0, 0, 0, 1, 2);
    vecs[5]  = mk(5'd9,  0, 0, 1, 1, 1, 2);
    vecs[6]  = mk(5'd0,  0, 0, 0, 0, 1, 3);
    vecs[7]  = mk(5'd31, 0, 0, 1, 1, 1, 3);
    vecs[8]  = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[9]  = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[10] = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[11] = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[12] = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[13] = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[14] = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[15] = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[16] = mk(5'd31, 0, 0, 1, 1, 1, 4);
    vecs[17] = mk(5'd0,  0, 0, 0, 0, 1, 4);
    vecs[18] = mk(5'd9,  0, 0, 1, 1, 1, 4);
    vecs[19] = mk(5'd9,  1, 0, 1, 1, 0, 0);
    vecs[20] = mk(5'd9,  0, 0, 1, 1, 1, 0);
    vecs[21] = mk(5'd0,  0, 0, 0, 0, 1, 0);
    vecs[22] = mk(5'd9,  0, 0, 1, 1, 1, 0);
    vecs[23] = mk(5'd0,  0, 0, 0, 0, 1, 1);
    vecs[24] = mk(5'd9,  0, 0, 1, 1, 1, 1);
    vecs[25] = mk(5'd9,  0, 1, 1, 0, 0, 0);
    vecs[26] = mk(5'd9,  0, 0, 1, 1, 0, 0);
    vecs[27] = mk(5'd9,  0, 0, 1, 1, 1, 1);

    x   = 5'd0;
    clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_yq",  0, yq8,  0);
    check("rst_st",  0, st8,  0);
    check("rst_cnt", 0, cnt8, 0);
    check("rst_cnt2", 0, cnt2, 0);

    // Exhaustive decode sweep, combinational, checked while still in reset.
    for (int i = 0; i < 32; i++) begin
      logic e;
      e = 1'b0;
      foreach (alarm_codes[k]) if (alarm_codes[k] == i) e = 1'b1;
      x = i[4:0];
      #20;
      check("sweep_y", i, y8, e);
      check("sweep_y2", i, y2, e);
    end

    @(negedge clk);
    x   = 5'd0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      x   = vecs[i].x;
      clr = vecs[i].clr;
      rst = vecs[i].rst;
      #1;
      check("vec_y", i, y8, vecs[i].exp_y);
      @(posedge clk);
      #1;
      check("vec_yq",  i, yq8,  vecs[i].exp_yq);
      check("vec_st",  i, st8,  vecs[i].exp_st);
      check("vec_cnt", i, cnt8, vecs[i].exp_cnt);
    end
    clr = 1'b0;
    rst = 1'b0;

    // Saturation on the 2-bit instance: five separate alarm pulses.
    rst = 1'b1;
    x   = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("sat_start", 0, cnt2, 0);
    for (int p = 1; p <= 5; p++) begin
      x = 5'd9;
      @(posedge clk);
      #1;
      x = 5'd0;
      @(posedge clk);
      #1;
      check("sat_cnt2", p, cnt2, (p > 3) ? 3 : p);
    end
    check("sat_st2", 0, st2, 1);
    check("sat_cnt8", 0, cnt8, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_circuit.md
ALARM_CIRCUIT -- requirements
Module: alarm_circuit

Interface
REQ-001 Parameter CNT_W, default 8, width of the alarm event counter.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 x4  input  1  sensor input, MSB of 5-bit code x = {x4,x3,x2,x1,x0}.
REQ-005 x3  input  1  sensor input bit 3.
REQ-006 x2  input  1  sensor input bit 2.
REQ-007 x1  input  1  sensor input bit 1.
REQ-008 x0  input  1  sensor input, LSB.
REQ-009 clr  input  1  synchronous clear of the sticky flag and the counter.
REQ-010 y  output  1  combinational alarm decode of current x.
REQ-011 y_q  output  1  y registered; 1-cycle latency.
REQ-012 alarm_sticky  output  1  set once y_q has been 1; held until clr or rst.
REQ-013 alarm_cnt  output  CNT_W  count of y_q rising edges (0->1), saturating.

Function
REQ-014 y SHALL be purely combinational, with no clock dependency.
REQ-015 y SHALL be 1 exactly for x in {2,3,6,9,13,16,18,19,21,24,25,28,29,31} (decimal) and 0 for all other codes.
REQ-016 Equivalently, y SHALL equal bit x of the 32-bit constant 32'hB32D_224C.
REQ-017 y_q SHALL equal the value y had before the previous rising clk edge.
REQ-018 alarm_sticky SHALL be set on the edge after y_q=1.
REQ-019 alarm_sticky SHALL stay set until clr=1 or rst=1.
REQ-020 A rising edge of y_q is y_q=1 while the internal previous-y_q register is 0.
REQ-021 alarm_cnt SHALL increment by 1 on each rising edge of y_q.
REQ-022 alarm_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 If clr=1 and a rising edge occur in the same cycle, clr SHALL win: alarm_cnt=0 and alarm_sticky=0 next cycle.
REQ-024 clr SHALL NOT affect y or y_q.
REQ-025 Any X/Z on x is outside scope; only defined 0/1 inputs are specified.

Reset
REQ-026 While rst=1 at a rising edge, the following SHALL all be 0 on the next cycle: y_q, the previous-y_q register, alarm_sticky, alarm_cnt.
REQ-027 rst SHALL take priority over clr and over counting.
REQ-028 y SHALL track x even during reset.
REQ-029 Reset asserted mid-count SHALL zero the count with no partial update.
REQ-030 After rst deasserts, the first rising edge of y_q SHALL count as 1.

Structure
REQ-031 Shared package alarm_pkg SHALL hold ALARM_TT = 32'hB32D_224C and the default CNT_W.
REQ-032 One sub-module alarm_decode (inputs: 5-bit code; output: y) SHALL implement the table lookup.
REQ-033 alarm_circuit SHALL contain the registers, edge detect, sticky flag and saturating counter.

Verification
REQ-034 Exhaustive sweep, x = 0..31 at 20 ns per step -> y matches REQ-015 for every code (e.g. x=2 -> 1, x=7 -> 0, x=16 -> 1, x=17 -> 0, x=31 -> 1).
REQ-035 Latency check: x=0 then x=9 -> y=1 immediately; y_q=1 exactly one clk edge later.
REQ-036 Counting: x toggles 9,0,9,0,9 -> alarm_cnt=3 and alarm_sticky=1.
REQ-037 Hold: x held at 31 for 10 cycles -> alarm_cnt increments only once.
REQ-038 Saturation, CNT_W=2: 5 rising edges -> alarm_cnt stays 3.
REQ-039 Clear and reset: clr=1 coinciding with a rising edge -> cnt=0, sticky=0 next cycle; rst=1 mid-run -> all registered outputs 0 next cycle while y still decodes x.
